// File: rtl/sketch_wb_arbiter_if.sv
// Bus bundle for the sketch write-back scheduler: eight lane sketch streams in,
// one AXI4 write master out. The scheduler uses "master", the memory side uses "slave".
interface sketch_wb_arbiter_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64
);
  logic [LANES*DATA_W-1:0] s_tdata;
  logic [LANES-1:0]        s_tvalid;
  logic [LANES-1:0]        s_tready;
  logic [LANES*ADDR_W-1:0] sketch_ptr;
  logic [ADDR_W-1:0]       m_awaddr;
  logic [7:0]              m_awlen;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_wlast;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;

  modport master (
    input  s_tdata, s_tvalid, sketch_ptr, m_awready, m_wready, m_bresp, m_bvalid,
    output s_tready, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready
  );

  modport slave (
    output s_tdata, s_tvalid, sketch_ptr, m_awready, m_wready, m_bresp, m_bvalid,
    input  s_tready, m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready
  );
endinterface

// File: rtl/sketch_wb_arbiter.sv
// Round-robin write-back scheduler: grants one HLL lane at a time and moves its
// whole sketch as a single AXI4 write burst; W beats pass straight through.
module sketch_wb_arbiter #(
  parameter int LANES  = 8,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int BEATS  = 128
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  sketch_wb_arbiter_if.master  bus,
  output logic [LANES-1:0]     wb_done,
  output logic [LANES-1:0]     wb_err,
  output logic                 busy
);
  localparam int         LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state_r;
  logic [LW-1:0]     grant_r;
  logic [LW-1:0]     rr_ptr_r;
  logic [7:0]        beat_cnt_r;
  logic [ADDR_W-1:0] awaddr_r;
  logic              awvalid_r;
  logic              bready_r;
  logic              busy_r;
  logic [LANES-1:0]  wb_done_r;
  logic [LANES-1:0]  wb_err_r;
  logic [LW-1:0]     pick_s;
  logic [LW-1:0]     rr_next_s;
  logic              w_hs_s;

  // First requesting lane at or after ptr, wrapping modulo LANES.
  function automatic logic [LW-1:0] rr_pick(input logic [LANES-1:0] req, input logic [LW-1:0] ptr);
    logic [LW-1:0] pick;
    logic [LW-1:0] idx;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      idx = LW'((int'(ptr) + k) % LANES);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Round-robin candidate and the pointer value that follows it.
  always_comb begin
    pick_s = rr_pick(bus.s_tvalid, rr_ptr_r);
    if (int'(pick_s) == LANES - 1) begin
      rr_next_s = {LW{1'b0}};
    end else begin
      rr_next_s = pick_s + LW'(1);
    end
  end

  // Zero-latency W pass-through from the granted lane, only while in DATA.
  always_comb begin
    if (state_r == ST_DATA) begin
      bus.m_wdata  = bus.s_tdata[int'(grant_r)*DATA_W +: DATA_W];
      bus.m_wvalid = bus.s_tvalid[grant_r];
      bus.s_tready = {{(LANES-1){1'b0}}, bus.m_wready} << grant_r;
      bus.m_wlast  = (beat_cnt_r == LAST_BEAT);
    end else begin
      bus.m_wdata  = {DATA_W{1'b0}};
      bus.m_wvalid = 1'b0;
      bus.s_tready = {LANES{1'b0}};
      bus.m_wlast  = 1'b0;
    end
  end

  assign w_hs_s = bus.m_wvalid & bus.m_wready;

  // Burst sequencing FSM with its registered outputs.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= {LW{1'b0}};
      rr_ptr_r   <= {LW{1'b0}};
      beat_cnt_r <= 8'd0;
      awaddr_r   <= {ADDR_W{1'b0}};
      awvalid_r  <= 1'b0;
      bready_r   <= 1'b0;
      busy_r     <= 1'b0;
      wb_done_r  <= {LANES{1'b0}};
      wb_err_r   <= {LANES{1'b0}};
    end else begin
      wb_done_r <= {LANES{1'b0}};
      case (state_r)
        ST_IDLE: begin
          // The pointer is captured here only; later changes do not touch this burst.
          if (|bus.s_tvalid) begin
            grant_r   <= pick_s;
            awaddr_r  <= bus.sketch_ptr[int'(pick_s)*ADDR_W +: ADDR_W];
            rr_ptr_r  <= rr_next_s;
            awvalid_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.m_awready) begin
            awvalid_r  <= 1'b0;
            beat_cnt_r <= 8'd0;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs_s) begin
            if (bus.m_wlast) begin
              bready_r <= 1'b1;
              state_r  <= ST_RESP;
            end else begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (bus.m_bvalid) begin
            bready_r           <= 1'b0;
            busy_r             <= 1'b0;
            wb_done_r[grant_r] <= 1'b1;
            if (bus.m_bresp != 2'b00) begin
              wb_err_r[grant_r] <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          awvalid_r <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_awaddr  = awaddr_r;
  assign bus.m_awlen   = LAST_BEAT;
  assign bus.m_awvalid = awvalid_r;
  assign bus.m_bready  = bready_r;
  assign wb_done       = wb_done_r;
  assign wb_err        = wb_err_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_sketch_wb_arbiter.sv
// Randomized scoreboard bench for sketch_wb_arbiter: lane sources and AXI sinks are
// driven from a reference request model; a monitor pops expectations as the DUT emits them.
module tb_sketch_wb_arbiter;
  localparam int LANES  = 8;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int BEATS  = 128;
  localparam int LW     = 3;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] lane; } aw_exp_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic last; } w_exp_t;
  typedef struct packed { logic [7:0] lane; logic err; } d_exp_t;

  logic             aclk;
  logic             areset_n;
  logic [LANES-1:0] wb_done;
  logic [LANES-1:0] wb_err;
  logic             busy;

  sketch_wb_arbiter_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sketch_wb_arbiter #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus),
    .wb_done  (wb_done),
    .wb_err   (wb_err),
    .busy     (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  d_exp_t  d_q[$];

  bit                lane_pend[LANES];
  int                lane_beat[LANES];
  int                lane_gen[LANES];
  logic [ADDR_W-1:0] ptr_val[LANES];
  logic [LANES-1:0]  err_mask = 8'h00;
  bit                gap_mode = 1'b0;
  bit                aw_delay_en = 1'b0;
  bit                b_random = 1'b0;
  bit                scramble_en = 1'b0;
  bit                chk_timing = 1'b0;
  int                scramble_lane = 0;
  int                model_ptr = 0;
  int                resp_lane = 0;

  function automatic logic [DATA_W-1:0] beat_data(input int lane, input int gen, input int beat);
    logic [31:0] w;
    w = (32'(lane) << 24) | (32'(gen & 255) << 16) | 32'(beat);
    return {(DATA_W/32){w}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic bit any_pend();
    bit p;
    p = 1'b0;
    for (int l = 0; l < LANES; l++) p = p | lane_pend[l];
    return p;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_s_tready",  DATA_W'(bus.s_tready),  DATA_W'(0));
    chk("rst_m_awvalid", DATA_W'(bus.m_awvalid), DATA_W'(0));
    chk("rst_m_wvalid",  DATA_W'(bus.m_wvalid),  DATA_W'(0));
    chk("rst_m_wlast",   DATA_W'(bus.m_wlast),   DATA_W'(0));
    chk("rst_m_bready",  DATA_W'(bus.m_bready),  DATA_W'(0));
    chk("rst_m_awaddr",  DATA_W'(bus.m_awaddr),  DATA_W'(0));
    chk("rst_m_wdata",   bus.m_wdata,            DATA_W'(0));
    chk("rst_wb_done",   DATA_W'(wb_done),       DATA_W'(0));
    chk("rst_wb_err",    DATA_W'(wb_err),        DATA_W'(0));
    chk("rst_busy",      DATA_W'(busy),          DATA_W'(0));
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge aclk);
      #3;
      if (aw_q.size() == 0 && w_q.size() == 0 && d_q.size() == 0 && !any_pend() && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: aw_q=%0d w_q=%0d d_q=%0d busy=%0b", aw_q.size(), w_q.size(), d_q.size(), busy);
      aw_q.delete();
      w_q.delete();
      d_q.delete();
      for (int l = 0; l < LANES; l++) begin
        lane_pend[l] = 1'b0;
        lane_beat[l] = 0;
      end
    end
  endtask

  // Reference model: lanes requesting together are served in circular order from model_ptr.
  task automatic run_batch(input logic [LANES-1:0] mask, input bit wait_done);
    int last;
    int l;
    last = -1;
    for (int k = 0; k < LANES; k++) begin
      l = (model_ptr + k) % LANES;
      if (mask[LW'(l)]) begin
        aw_q.push_back('{addr: ptr_val[l], lane: 8'(l)});
        for (int b = 0; b < BEATS; b++)
          w_q.push_back('{data: beat_data(l, lane_gen[l], b), last: (b == BEATS - 1)});
        d_q.push_back('{lane: 8'(l), err: err_mask[LW'(l)]});
        last = l;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % LANES;
    for (int i = 0; i < LANES; i++) if (mask[LW'(i)]) lane_pend[i] = 1'b1;
    if (wait_done) wait_idle(20000);
  endtask

  // Driver: lane sources and AXI sinks; inputs change on the falling edge.
  initial begin
    bit [LANES-1:0] hs;
    bit             aw_hs;
    bit             aw_wait_seen;
    int             aw_wait;
    hs = '0;
    aw_hs = 1'b0;
    aw_wait_seen = 1'b0;
    aw_wait = 0;
    forever begin
      @(negedge aclk);
      if (areset_n) begin
        for (int i = 0; i < LANES; i++) begin
          if (hs[i]) begin
            lane_beat[i]++;
            if (lane_beat[i] == BEATS) begin
              lane_beat[i] = 0;
              lane_pend[i] = 1'b0;
              lane_gen[i]++;
              resp_lane = i;
            end
          end
        end
        if (aw_hs) aw_wait = 0;
        if (scramble_en && aw_wait_seen) ptr_val[scramble_lane] = {$urandom, $urandom};
      end else begin
        aw_wait = 0;
      end
      for (int i = 0; i < LANES; i++) begin
        bus.s_tvalid[i] = lane_pend[i] && !(gap_mode && lane_beat[i] > 0 && $urandom_range(0, 3) == 0);
        bus.s_tdata[i*DATA_W +: DATA_W] = beat_data(i, lane_gen[i], lane_beat[i]);
        bus.sketch_ptr[i*ADDR_W +: ADDR_W] = ptr_val[i];
      end
      bus.m_wready  = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m_awready = aw_delay_en ? (aw_wait >= 10) : 1'b1;
      bus.m_bvalid  = b_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_bresp   = err_mask[LW'(resp_lane)] ? 2'b10 : 2'b00;
      #1;
      hs           = areset_n ? (bus.s_tvalid & bus.s_tready) : '0;
      aw_hs        = areset_n && bus.m_awvalid && bus.m_awready;
      aw_wait_seen = areset_n && bus.m_awvalid && !bus.m_awready;
      if (aw_wait_seen) aw_wait++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents AW, W or completion.
  initial begin
    int               cur_lane;
    bit               aw_seen;
    int               busy_cnt;
    logic [LANES-1:0] exp_err;
    logic [LANES-1:0] allowed;
    bit               prev_wait;
    logic [ADDR_W-1:0] prev_addr;
    aw_exp_t          ea;
    w_exp_t           ew;
    d_exp_t           ed;
    cur_lane = 0; aw_seen = 1'b0; busy_cnt = 0; exp_err = '0; prev_wait = 1'b0; prev_addr = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!areset_n) begin
        aw_seen = 1'b0; busy_cnt = 0; exp_err = '0; prev_wait = 1'b0;
      end else begin
        allowed = aw_seen ? (LANES'(1) << cur_lane) : '0;
        if (busy) begin
          busy_cnt++;
          chk("s_tready_grant_only", DATA_W'(bus.s_tready & ~allowed), DATA_W'(0));
        end
        if (bus.m_awvalid) begin
          if (prev_wait) chk("awaddr_stable", DATA_W'(bus.m_awaddr), DATA_W'(prev_addr));
          if (bus.m_awready) begin
            if (aw_q.size() == 0) fail_msg("aw_unexpected", $sformatf("addr %0h", bus.m_awaddr));
            else begin
              ea = aw_q.pop_front();
              chk("awaddr", DATA_W'(bus.m_awaddr), DATA_W'(ea.addr));
              chk("awlen", DATA_W'(bus.m_awlen), DATA_W'(BEATS - 1));
              cur_lane = int'(ea.lane);
              aw_seen = 1'b1;
            end
          end
        end
        prev_wait = bus.m_awvalid && !bus.m_awready;
        prev_addr = bus.m_awaddr;
        if (bus.m_wvalid && bus.m_wready) begin
          if (!aw_seen) fail_msg("w_before_aw", $sformatf("wdata %0h", bus.m_wdata[31:0]));
          else if (w_q.size() == 0) fail_msg("w_unexpected", $sformatf("wdata %0h", bus.m_wdata[31:0]));
          else begin
            ew = w_q.pop_front();
            chk("wdata", bus.m_wdata, ew.data);
            chk("wlast", DATA_W'(bus.m_wlast), DATA_W'(ew.last));
          end
          if (bus.m_wlast) aw_seen = 1'b0;
        end
        if (wb_done != '0) begin
          if (d_q.size() == 0) fail_msg("done_unexpected", $sformatf("wb_done %0h", wb_done));
          else begin
            ed = d_q.pop_front();
            chk("wb_done", DATA_W'(wb_done), DATA_W'(LANES'(1) << ed.lane));
            exp_err = exp_err | (LANES'(ed.err) << ed.lane);
            chk("wb_err", DATA_W'(wb_err), DATA_W'(exp_err));
            if (chk_timing) chk("burst_busy_cycles", DATA_W'(busy_cnt), DATA_W'(BEATS + 2));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main sequence of scenarios.
  initial begin
    logic [LANES-1:0] m;
    bit               reached;
    areset_n = 1'b0;
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.sketch_ptr = '0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    for (int l = 0; l < LANES; l++) begin
      lane_pend[l] = 1'b0; lane_beat[l] = 0; lane_gen[l] = 0;
      ptr_val[l] = {$urandom, $urandom} & ~64'h1FFF;
    end
    repeat (3) @(negedge aclk);
    #1;
    check_reset_outputs();
    @(negedge aclk);
    areset_n = 1'b1;

    chk_timing = 1'b1;
    run_batch(8'hFF, 1'b1);
    ptr_val[3] = 64'h1000_0000;
    run_batch(8'h08, 1'b1);
    chk_timing = 1'b0;

    run_batch(8'h04, 1'b1);
    run_batch(8'h22, 1'b1);

    gap_mode = 1'b1; aw_delay_en = 1'b1; b_random = 1'b1; scramble_en = 1'b1;
    repeat (3) begin
      scramble_lane = $urandom_range(0, LANES - 1);
      run_batch(LANES'(1) << scramble_lane, 1'b1);
    end
    scramble_en = 1'b0;
    repeat (2) begin
      m = 8'($urandom_range(1, 255));
      run_batch(m, 1'b1);
    end

    gap_mode = 1'b0; aw_delay_en = 1'b0; b_random = 1'b0;
    err_mask = 8'h40;
    run_batch(8'h41, 1'b1);
    err_mask = 8'h00;
    run_batch(8'h44, 1'b1);
    chk("wb_err_sticky", DATA_W'(wb_err), DATA_W'(8'h40));

    run_batch(8'h10, 1'b0);
    reached = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge aclk);
      #2;
      if (lane_beat[4] >= 50) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midburst_reach: lane 4 beat %0d, expected 50", lane_beat[4]);
    end
    #1;
    areset_n = 1'b0;
    #1;
    check_reset_outputs();
    aw_q.delete(); w_q.delete(); d_q.delete();
    for (int l = 0; l < LANES; l++) begin
      lane_pend[l] = 1'b0;
      lane_beat[l] = 0;
    end
    model_ptr = 0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    run_batch(8'h90, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
